// File: rtl/systolic_drain.sv
// Output-side collector for the weight-stationary array: deskews bottom-row column sums,
// buffers aligned rows in a FIFO and streams them out with valid/ready back-pressure.
module systolic_drain #(
    parameter int DWIDTH       = 8,
    parameter int COLS         = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int STALL_MARGIN = 6
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear_i,
    input  logic                             in_valid_i,
    input  logic [COLS*2*DWIDTH-1:0]         col_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [COLS*2*DWIDTH-1:0]         out_data_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic                             stall_o,
    output logic                             overflow_o
);

    localparam int RW = 2 * DWIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);

    logic [COLS-1:0]      r_vld;
    logic [COLS*RW-1:0]   w_row;
    logic [RW*COLS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_stall;
    logic                 r_overflow;

    logic                 w_flush;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr;
    logic                 w_drop;
    logic [CW-1:0]        w_count_nxt;
    logic [CW-1:0]        w_free_nxt;

    assign w_flush = !reset_n || clear_i;

    // Valid travels COLS stages so it meets the last column's data at the stage outputs.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[COLS-2:0], in_valid_i};
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int N = COLS - c;
        logic [RW-1:0] r_sh [N];

        always_ff @(posedge clk) begin
            if (w_flush) begin
                for (int i = 0; i < N; i++) begin
                    r_sh[i] <= '0;
                end
            end else begin
                r_sh[0] <= col_data_i[c*RW +: RW];
                for (int i = 1; i < N; i++) begin
                    r_sh[i] <= r_sh[i-1];
                end
            end
        end

        assign w_row[c*RW +: RW] = r_sh[N-1];
    end

    assign w_push = r_vld[COLS-1];

    always_comb begin
        w_pop       = (r_count != '0) && out_ready_i;
        w_full      = (r_count == DEPTH_C);
        w_wr        = w_push && (!w_full || w_pop);
        w_drop      = w_push && w_full && !w_pop;
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        w_free_nxt  = DEPTH_C - w_count_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_stall <= (w_free_nxt <= MARGIN_C);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!w_flush && w_wr) begin
            r_mem[r_wptr] <= w_row;
        end
    end

    assign out_valid_o = (r_count != '0);
    assign out_data_o  = out_valid_o ? r_mem[r_rptr] : '0;
    assign count_o     = r_count;
    assign stall_o     = r_stall;
    assign overflow_o  = r_overflow;

endmodule
